// File: rtl/data_mem_sram_bridge.sv
// data_mem_sram_bridge
//   Memory-side endpoint of the data-memory channel bus. Per-channel valid/ready
//   read and write requests are arbitrated round-robin and serialised onto one
//   single-port synchronous SRAM with a fixed read latency. Each completed access
//   returns a one-cycle ready pulse on its channel (plus data for reads).
//
// Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   mem_read_valid      per-channel read request
//   mem_read_address    per-channel read address
//   mem_read_ready      one-cycle read-complete pulse
//   mem_read_data       per-channel read data, held until the next read on that channel
//   mem_write_valid     per-channel write request
//   mem_write_address   per-channel write address
//   mem_write_data      per-channel write data
//   mem_write_ready     one-cycle write-complete pulse
//   sram_en/we/addr/wdata  SRAM access strobe, direction, address, write data
//   sram_rdata          SRAM read data, SRAM_LATENCY cycles after a read strobe
//   busy                high whenever the FSM is not IDLE
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | arbitrate; latch winning channel, op, address and data
// ISSUE    | sram_en high for exactly this cycle
// WAIT     | read only: SRAM_LATENCY-1 cycles for read data to arrive
// RESPOND  | capture read data / raise ready for the granted channel

module data_mem_sram_bridge #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  output logic                                   sram_en,
  output logic                                   sram_we,
  output logic [ADDR_BITS-1:0]                   sram_addr,
  output logic [DATA_BITS-1:0]                   sram_wdata,
  input  logic [DATA_BITS-1:0]                   sram_rdata,
  output logic                                   busy
);

  localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int WAIT_BITS = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                                state_q, state_d;
  logic [CH_BITS-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_CHANNELS-1:0]               served_q, served_d;
  logic [NUM_CHANNELS-1:0]               served_wr_q, served_wr_d;
  logic [CH_BITS-1:0]                    ch_q, ch_d;
  logic                                  op_we_q, op_we_d;
  logic [WAIT_BITS-1:0]                  wait_cnt_q, wait_cnt_d;

  logic                                  sram_en_q, sram_en_d;
  logic                                  sram_we_q, sram_we_d;
  logic [ADDR_BITS-1:0]                  sram_addr_q, sram_addr_d;
  logic [DATA_BITS-1:0]                  sram_wdata_q, sram_wdata_d;
  logic [NUM_CHANNELS-1:0]               mem_read_ready_q, mem_read_ready_d;
  logic [NUM_CHANNELS-1:0]               mem_write_ready_q, mem_write_ready_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data_q, mem_read_data_d;
  logic                                  busy_q, busy_d;

  logic [NUM_CHANNELS-1:0]               eligible;
  logic                                  grant_found;
  logic [CH_BITS-1:0]                    grant_ch;
  logic [CH_BITS-1:0]                    grant_nxt;

  // Round-robin search starting at rr_ptr, wrapping.
  always_comb begin
    eligible    = (mem_read_valid | mem_write_valid) & ~served_q;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % NUM_CHANNELS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_ch    = CH_BITS'(idx);
      end
    end
    grant_nxt = CH_BITS'((int'(grant_ch) + 1) % NUM_CHANNELS);
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    served_d          = served_q;
    served_wr_d       = served_wr_q;
    ch_d              = ch_q;
    op_we_d           = op_we_q;
    wait_cnt_d        = wait_cnt_q;
    sram_en_d         = 1'b0;
    sram_we_d         = sram_we_q;
    sram_addr_d       = sram_addr_q;
    sram_wdata_d      = sram_wdata_q;
    mem_read_ready_d  = '0;
    mem_write_ready_d = '0;
    mem_read_data_d   = mem_read_data_q;

    // served remembers which request (read or write) was retired on a channel.
    // It clears once that request's valid is seen low, so a channel that raised
    // both valids gets its read granted after the write valid drops, while a
    // valid simply held high after completion is never served twice.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (served_q[c] && !(served_wr_q[c] ? mem_write_valid[c] : mem_read_valid[c]))
        served_d[c] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          ch_d     = grant_ch;
          rr_ptr_d = grant_nxt;
          // Write wins when a channel presents both directions.
          op_we_d      = mem_write_valid[grant_ch];
          sram_en_d    = 1'b1;
          sram_we_d    = mem_write_valid[grant_ch];
          sram_addr_d  = mem_write_valid[grant_ch] ? mem_write_address[grant_ch]
                                                   : mem_read_address[grant_ch];
          sram_wdata_d = mem_write_data[grant_ch];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (op_we_q || SRAM_LATENCY == 1) begin
          state_d = RESPOND;
        end else begin
          wait_cnt_d = WAIT_BITS'(SRAM_LATENCY - 2);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = RESPOND;
        else                  wait_cnt_d = wait_cnt_q - 1'b1;
      end
      RESPOND: begin
        served_d[ch_q]    = 1'b1;
        served_wr_d[ch_q] = op_we_q;
        if (op_we_q) begin
          mem_write_ready_d[ch_q] = 1'b1;
        end else begin
          mem_read_ready_d[ch_q] = 1'b1;
          mem_read_data_d[ch_q]  = sram_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      rr_ptr_q          <= '0;
      served_q          <= '0;
      served_wr_q       <= '0;
      ch_q              <= '0;
      op_we_q           <= 1'b0;
      wait_cnt_q        <= '0;
      sram_en_q         <= 1'b0;
      sram_we_q         <= 1'b0;
      sram_addr_q       <= '0;
      sram_wdata_q      <= '0;
      mem_read_ready_q  <= '0;
      mem_write_ready_q <= '0;
      mem_read_data_q   <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      served_q          <= served_d;
      served_wr_q       <= served_wr_d;
      ch_q              <= ch_d;
      op_we_q           <= op_we_d;
      wait_cnt_q        <= wait_cnt_d;
      sram_en_q         <= sram_en_d;
      sram_we_q         <= sram_we_d;
      sram_addr_q       <= sram_addr_d;
      sram_wdata_q      <= sram_wdata_d;
      mem_read_ready_q  <= mem_read_ready_d;
      mem_write_ready_q <= mem_write_ready_d;
      mem_read_data_q   <= mem_read_data_d;
      busy_q            <= busy_d;
    end
  end

  assign mem_read_ready  = mem_read_ready_q;
  assign mem_write_ready = mem_write_ready_q;
  assign mem_read_data   = mem_read_data_q;
  assign sram_en         = sram_en_q;
  assign sram_we         = sram_we_q;
  assign sram_addr       = sram_addr_q;
  assign sram_wdata      = sram_wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_data_mem_sram_bridge.sv
module tb_data_mem_sram_bridge;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // latency-1 instance
  logic reset;
  logic [NC-1:0] rv, wv, rrdy, wrdy;
  logic [NC-1:0][AB-1:0] ra, wa;
  logic [NC-1:0][DB-1:0] wd, rdat;
  logic s_en, s_we, busy;
  logic [AB-1:0] s_addr;
  logic [DB-1:0] s_wd, s_rd;

  // latency-3 instance
  logic rst3;
  logic [NC-1:0] rv3, wv3, rrdy3, wrdy3;
  logic [NC-1:0][AB-1:0] ra3, wa3;
  logic [NC-1:0][DB-1:0] wd3, rdat3;
  logic s_en3, s_we3, busy3;
  logic [AB-1:0] s_addr3;
  logic [DB-1:0] s_wd3, s_rd3;

  data_mem_sram_bridge #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .SRAM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rrdy), .mem_read_data(rdat),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wrdy),
    .sram_en(s_en), .sram_we(s_we), .sram_addr(s_addr), .sram_wdata(s_wd), .sram_rdata(s_rd),
    .busy(busy));

  data_mem_sram_bridge #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .SRAM_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3),
    .mem_read_valid(rv3), .mem_read_address(ra3), .mem_read_ready(rrdy3), .mem_read_data(rdat3),
    .mem_write_valid(wv3), .mem_write_address(wa3), .mem_write_data(wd3), .mem_write_ready(wrdy3),
    .sram_en(s_en3), .sram_we(s_we3), .sram_addr(s_addr3), .sram_wdata(s_wd3), .sram_rdata(s_rd3),
    .busy(busy3));

  // SRAM models: unwritten locations read a fixed pattern; 0x10 holds 0xAB.
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hAB : (a ^ 8'hC3);
  endfunction

  logic [7:0] mem1 [256];
  logic [255:0] wm1 = '0;
  always @(posedge clk) begin
    if (s_en && s_we) begin
      mem1[s_addr] <= s_wd;
      wm1[s_addr]  <= 1'b1;
    end
    s_rd <= (s_en && !s_we) ? (wm1[s_addr] ? mem1[s_addr] : init_val(s_addr)) : 8'hEE;
  end

  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    pipe3[0] <= (s_en3 && !s_we3) ? init_val(s_addr3) : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign s_rd3 = pipe3[2];

  // scoreboard
  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input int ch, input bit wr, input logic [7:0] data, input int at);
    exp_t e;
    e.ch = ch; e.wr = wr; e.data = data; e.at = at;
    q1.push_back(e);
  endtask

  task automatic push3(input int ch, input bit wr, input logic [7:0] data, input int at);
    exp_t e;
    e.ch = ch; e.wr = wr; e.data = data; e.at = at;
    q3.push_back(e);
  endtask

  // monitor: pops one expectation per ready pulse
  initial begin : mon
    exp_t e;
    int ach;
    forever begin
      @(negedge clk);
      if (!reset && (|{rrdy, wrdy})) begin
        chk("dut1 ready one-hot", $countones({rrdy, wrdy}), 1);
        ach = 0;
        for (int c = NC - 1; c >= 0; c--) if (rrdy[c] || wrdy[c]) ach = c;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 unexpected ready: rd=%b wr=%b, required none (cycle %0d)", rrdy, wrdy, cyc);
        end else begin
          e = q1.pop_front();
          chk("dut1 ready channel", ach, e.ch);
          chk("dut1 ready is write", {31'd0, |wrdy}, {31'd0, e.wr});
          if (!e.wr) chk("dut1 read data", rdat[e.ch], e.data);
          if (e.at >= 0) chk("dut1 ready cycle", cyc, e.at);
        end
      end
      if (!rst3 && (|{rrdy3, wrdy3})) begin
        chk("dut3 ready one-hot", $countones({rrdy3, wrdy3}), 1);
        ach = 0;
        for (int c = NC - 1; c >= 0; c--) if (rrdy3[c] || wrdy3[c]) ach = c;
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut3 unexpected ready: rd=%b wr=%b, required none (cycle %0d)", rrdy3, wrdy3, cyc);
        end else begin
          e = q3.pop_front();
          chk("dut3 ready channel", ach, e.ch);
          chk("dut3 ready is write", {31'd0, |wrdy3}, {31'd0, e.wr});
          if (!e.wr) chk("dut3 read data", rdat3[e.ch], e.data);
          if (e.at >= 0) chk("dut3 ready cycle", cyc, e.at);
        end
      end
    end
  end

  // requester behaviour applied every cycle
  bit [NC-1:0] drop_r, drop_w, pend;
  int rearm [NC];

  task automatic step();
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      if (pend[c]) begin
        rv[c]   = 1'b1;
        pend[c] = 1'b0;
      end else if (rrdy[c] && drop_r[c]) begin
        rv[c] = 1'b0;
        if (rearm[c] > 0) begin
          rearm[c]--;
          pend[c] = 1'b1;
        end
      end
      if (wrdy[c] && drop_w[c]) wv[c] = 1'b0;
    end
    rv3 = rv3 & ~rrdy3;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    step();
    while ((q1.size() != 0 || q3.size() != 0 || busy || busy3) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s timeout: pending q1=%0d q3=%0d, required 0", name, q1.size(), q3.size());
    end
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; rst3 = 1'b1;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    rv3 = '0; wv3 = '0; ra3 = '0; wa3 = '0; wd3 = '0;
    drop_r = '1; drop_w = '1; pend = '0;
    for (int c = 0; c < NC; c++) rearm[c] = 0;
    repeat (3) step();

    chk("reset read_ready", rrdy, 0);
    chk("reset write_ready", wrdy, 0);
    chk("reset read_data", rdat, 0);
    chk("reset sram_en", s_en, 0);
    chk("reset sram_we", s_we, 0);
    chk("reset sram_addr", s_addr, 0);
    chk("reset sram_wdata", s_wd, 0);
    chk("reset busy", busy, 0);
    chk("reset busy3", busy3, 0);
    chk("reset read_data3", rdat3, 0);
    reset = 1'b0; rst3 = 1'b0;

    // 1: single read, address changed after grant must be ignored
    step();
    rv[0] = 1'b1; ra[0] = 8'h10;
    push1(0, 1'b0, 8'hAB, cyc + 3);
    step();
    chk("t1 sram_en in ISSUE", s_en, 1);
    chk("t1 sram_we in ISSUE", s_we, 0);
    chk("t1 sram_addr in ISSUE", s_addr, 8'h10);
    ra[0] = 8'h99;
    step();
    chk("t1 sram_en after ISSUE", s_en, 0);
    wait_done("t1");

    // 2: all four channels at once from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t2 read_data cleared by reset", rdat, 0);
    step();
    rv = '1;
    ra[0] = 8'h00; ra[1] = 8'h01; ra[2] = 8'h02; ra[3] = 8'h03;
    push1(0, 1'b0, 8'hC3, cyc + 3);
    push1(1, 1'b0, 8'hC2, cyc + 6);
    push1(2, 1'b0, 8'hC1, cyc + 9);
    push1(3, 1'b0, 8'hC0, cyc + 12);
    wait_done("t2");

    // 3: write then read back on other channels
    step();
    wv[2] = 1'b1; wa[2] = 8'h20; wd[2] = 8'h5A;
    push1(2, 1'b1, 8'h00, cyc + 3);
    step();
    chk("t3 sram_en write", s_en, 1);
    chk("t3 sram_we write", s_we, 1);
    chk("t3 sram_addr write", s_addr, 8'h20);
    chk("t3 sram_wdata write", s_wd, 8'h5A);
    wait_done("t3w");
    step();
    rv[1] = 1'b1; ra[1] = 8'h20;
    push1(1, 1'b0, 8'h5A, cyc + 3);
    wait_done("t3r1");
    step();
    rv[2] = 1'b1; ra[2] = 8'h20;
    push1(2, 1'b0, 8'h5A, cyc + 3);
    wait_done("t3r2");

    // 4: ch3 read+write together with rr_ptr at 3; read valid held after ready
    step();
    drop_r[3] = 1'b0;
    rv[3] = 1'b1; wv[3] = 1'b1; ra[3] = 8'h30; wa[3] = 8'h30; wd[3] = 8'h77;
    push1(3, 1'b1, 8'h00, cyc + 3);
    push1(3, 1'b0, 8'h77, -1);
    wait_done("t4");
    repeat (8) step();
    chk("t4 idle with valid held", busy, 0);
    rv[3] = 1'b0; drop_r[3] = 1'b1;
    step();
    step();

    // 5: ch1 and ch3 re-request immediately; grants must alternate
    rv[1] = 1'b1; ra[1] = 8'h40;
    rv[3] = 1'b1; ra[3] = 8'h41;
    rearm[1] = 1; rearm[3] = 1;
    push1(1, 1'b0, 8'h83, cyc + 3);
    push1(3, 1'b0, 8'h82, cyc + 6);
    push1(1, 1'b0, 8'h83, cyc + 9);
    push1(3, 1'b0, 8'h82, cyc + 12);
    wait_done("t5");

    // 6: latency-3 instance
    step();
    rv3[0] = 1'b1; ra3[0] = 8'h10;
    push3(0, 1'b0, 8'hAB, cyc + 5);
    step();
    chk("t6 busy3 in ISSUE", busy3, 1);
    chk("t6 sram_en3 in ISSUE", s_en3, 1);
    wait_done("t6");
    step();
    rv3[0] = 1'b1; ra3[0] = 8'h11;
    step();
    step();
    chk("t6 busy3 in WAIT", busy3, 1);
    chk("t6 sram_en3 in WAIT", s_en3, 0);
    rst3 = 1'b1; rv3 = '0;
    step();
    chk("t6 busy3 after reset", busy3, 0);
    chk("t6 read_ready3 after reset", rrdy3, 0);
    rst3 = 1'b0;
    repeat (6) step();
    chk("t6 busy3 stays idle", busy3, 0);

    // read data held per channel since last read
    chk("held data ch0", rdat[0], 8'hC3);
    chk("held data ch1", rdat[1], 8'h83);
    chk("held data ch2", rdat[2], 8'h5A);
    chk("held data ch3", rdat[3], 8'h82);
    chk("dut1 outstanding expectations", q1.size(), 0);
    chk("dut3 outstanding expectations", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
